output_port_allocator: RTL
==========================

Name: output_port_allocator

Overview:
- Per-output-port arbiter and link driver; one instance per output direction of the router.
- Answers the switch's output requests: takes the request vector for its own output, grants exactly one input for a whole packet, and forwards that packet's flits onto the link.
- Tracks downstream buffer space with a credit counter and withholds the grant while no credit is left.
- Releases the grant after the tail flit, then re-arbitrates round-robin.

Parameters:
- PORT_ID, LOCAL, PORT_T: the output direction this instance drives; used only for debug tagging.
- BUF_DEPTH, 4: depth of the downstream input buffer; reset value of the credit counter.
- CREDIT_W, $clog2(BUF_DEPTH+1): width of the credit counter.

Ports:
- clk  in  1  single clock; every register uses the rising edge.
- rst  in  1  asynchronous, active-high reset.
- i_outport_req  in  NUM_OF_PORTS  bit k = input port k requests this output.
- o_outport_ack  out  NUM_OF_PORTS  one-hot grant to the owning input; all-zero when not granting.
- i_s2o  in  router_pipeline_bus_t  flit from the switch for this output.
- i_s2o_valid  in  1  i_s2o carries a flit this cycle.
- o_link_flit  out  router_pipeline_bus_t  registered flit to the neighbour or local sink.
- o_link_valid  out  1  o_link_flit valid.
- i_credit_return  in  1  downstream freed one buffer slot.
- o_credits  out  CREDIT_W  current credit count.
- o_busy  out  1  output is locked to an owner.
- o_credit_err  out  1  sticky flag: a credit came back while the counter was already full.

Behaviour:
- Reset (async, rst=1):
  - state=IDLE, owner=0, rr_ptr=0, credits=BUF_DEPTH.
  - o_outport_ack=0, o_link_valid=0, o_link_flit=0, o_busy=0, o_credit_err=0.
  - Reset mid-packet discards the owner and any in-flight flit; nothing is replayed.
- States: IDLE and LOCKED.
- IDLE:
  - If i_outport_req!=0 and credits!=0, select the first set bit searching from rr_ptr upward, wrapping modulo NUM_OF_PORTS.
  - Next cycle: owner=selection, state=LOCKED.
  - If credits==0, stay in IDLE and grant nothing.
- o_outport_ack[k] = (state==LOCKED && owner==k && credits!=0).
  - Decoded from registered state, so no combinational path from request to ack.
  - The first ack appears one cycle after the request is sampled.
- Accept condition: LOCKED && i_s2o_valid && credits!=0. On accept:
  - o_link_flit <= i_s2o and o_link_valid <= 1 (1-cycle latency).
  - credits decrement.
  - Otherwise o_link_valid <= 0.
- A flit presented while ack is low is not accepted; the upstream holds it.
- Tail release: when an accepted flit has flit.head.flit_type==TAIL_FLIT:
  - next cycle state=IDLE and rr_ptr=(owner+1) mod NUM_OF_PORTS.
  - Ack drops that same next cycle.
  - The earliest next grant is the cycle after, so there is a minimum 1-cycle gap between packets.
- Owner drops its request while LOCKED before the tail: the lock is held and the port stays reserved until the tail is accepted.
- Requests from non-owners while LOCKED are ignored; nothing is latched or queued.
- Credit counter:
  - accept and no return: decrement.
  - return and no accept: increment.
  - both in the same cycle: unchanged.
  - return while credits==BUF_DEPTH: ignored, o_credit_err<=1 (sticky until rst).
  - Never decrements below 0: the accept condition requires credits!=0.
- o_busy = (state==LOCKED).

Decomposition:
- router_pkg already supplies NUM_OF_PORTS, PORT_T, router_pipeline_bus_t and the TAIL_FLIT encoding.
- Add to router_pkg: typedef ALLOC_STATE_T {A_IDLE, A_LOCKED}.
- One sub-module, rr_arbiter:
  - Parameter N; inputs req[N] and ptr; outputs one-hot gnt and gnt_valid.
  - Purely combinational; reused later by the VC allocator.
- The credit counter stays inline.

Test Plan:
- Reset with BUF_DEPTH=4 -> o_credits=4, o_outport_ack=0, o_link_valid=0, o_busy=0, o_credit_err=0.
- req=5'b00100, 3-flit packet (HEAD, BODY, TAIL) on consecutive cycles -> ack=00100 one cycle after req; link shows the 3 flits one cycle after each accept; o_credits 4→1; ack=0 the cycle after the tail.
- req=5'b01011 held, each owner sends a 2-flit packet -> grant order 0, 1, 3 with a 1-cycle idle gap between packets; after 3, rr_ptr wraps and port 0 wins again.
- BUF_DEPTH=2, no returns, 4-flit packet -> 2 flits forwarded, then ack low with the flit held; one i_credit_return -> ack reasserts and 1 flit is forwarded.
- Credit return coinciding with an accept -> o_credits unchanged.
- rst asserted mid-packet after 1 of 3 flits -> all outputs return to reset values immediately; after release, the same request re-arbitrates from rr_ptr=0.
- 1 extra i_credit_return at credits=4 -> o_credits stays 4, o_credit_err=1 and stays 1 until rst.

Source files
------------

// File: rtl/router_pkg.sv
// Shared router types: port directions, flit layout and allocator state encoding.
package router_pkg;

   localparam int NUM_OF_PORTS = 5;
   localparam int PORT_W       = $clog2(NUM_OF_PORTS);

   typedef enum logic [2:0] {LOCAL, NORTH, EAST, SOUTH, WEST} PORT_T;

   typedef enum logic [1:0] {
      HEAD_FLIT = 2'd0,
      BODY_FLIT = 2'd1,
      TAIL_FLIT = 2'd2
   } FLIT_TYPE_T;

   typedef struct packed {
      FLIT_TYPE_T flit_type;
      PORT_T      dst_port;
      logic [1:0] vc_id;
   } flit_head_t;

   typedef struct packed {
      flit_head_t  head;
      logic [31:0] data;
   } router_pipeline_bus_t;

   typedef enum logic {A_IDLE, A_LOCKED} ALLOC_STATE_T;

endpackage

// File: rtl/output_port_allocator_if.sv
// Switch-side request/grant, flit and credit signals of one output port allocator.
interface output_port_allocator_if
   import router_pkg::*;
#(
   parameter int CREDIT_W = 3
);

   logic [NUM_OF_PORTS-1:0] i_outport_req;
   logic [NUM_OF_PORTS-1:0] o_outport_ack;
   router_pipeline_bus_t    i_s2o;
   logic                    i_s2o_valid;
   router_pipeline_bus_t    o_link_flit;
   logic                    o_link_valid;
   logic                    i_credit_return;
   logic [CREDIT_W-1:0]     o_credits;
   logic                    o_busy;
   logic                    o_credit_err;

   modport master (
      output i_outport_req, i_s2o, i_s2o_valid, i_credit_return,
      input  o_outport_ack, o_link_flit, o_link_valid, o_credits, o_busy, o_credit_err
   );

   modport slave (
      input  i_outport_req, i_s2o, i_s2o_valid, i_credit_return,
      output o_outport_ack, o_link_flit, o_link_valid, o_credits, o_busy, o_credit_err
   );

endinterface

// File: rtl/output_port_allocator_rr_arbiter.sv
// Combinational round-robin arbiter: first set request at or above ptr, wrapping modulo N.
module rr_arbiter #(
   parameter int N     = 4,
   parameter int PTR_W = (N > 1) ? $clog2(N) : 1
) (
   input  logic [N-1:0]     req,
   input  logic [PTR_W-1:0] ptr,
   output logic [N-1:0]     gnt,
   output logic             gnt_valid
);

   logic [PTR_W-1:0] idx;

   always_comb begin
      gnt       = '0;
      gnt_valid = 1'b0;
      idx       = '0;
      for (int i = 0; i < N; i++) begin
         idx = PTR_W'((int'(ptr) + i) % N);
         if (!gnt_valid && req[idx]) begin
            gnt[idx]  = 1'b1;
            gnt_valid = 1'b1;
         end
      end
   end

endmodule

// File: rtl/output_port_allocator.sv
// Per-output arbiter and link driver: locks one input for a whole packet, forwards
// its flits onto the link and gates everything on downstream credits.
module output_port_allocator
   import router_pkg::*;
#(
   parameter PORT_T PORT_ID   = LOCAL,
   parameter int    BUF_DEPTH = 4,
   parameter int    CREDIT_W  = $clog2(BUF_DEPTH + 1)
) (
   input logic                    clk,
   input logic                    rst,
   output_port_allocator_if.slave bus
);

   localparam logic [CREDIT_W-1:0] FULL = CREDIT_W'(BUF_DEPTH);

   ALLOC_STATE_T            state, next_state;
   logic [PORT_W-1:0]       owner, next_owner;
   logic [PORT_W-1:0]       rr_ptr, next_rr_ptr;
   logic [CREDIT_W-1:0]     credits;
   router_pipeline_bus_t    link_flit;
   logic                    link_valid;
   logic                    credit_err;
   logic [NUM_OF_PORTS-1:0] arb_gnt;
   logic                    arb_valid;
   logic [PORT_W-1:0]       gnt_idx;
   logic [NUM_OF_PORTS-1:0] ack;
   logic                    has_credit;
   logic                    accept;

   // Hierarchy tag so a debugger shows which direction this instance drives.
   if (PORT_ID == LOCAL) begin : g_tag_local_sink
   end else begin : g_tag_link
   end

   rr_arbiter #(
      .N     (NUM_OF_PORTS),
      .PTR_W (PORT_W)
   ) u_arb (
      .req       (bus.i_outport_req),
      .ptr       (rr_ptr),
      .gnt       (arb_gnt),
      .gnt_valid (arb_valid)
   );

   assign has_credit = (credits != '0);
   assign accept     = (state == A_LOCKED) && bus.i_s2o_valid && has_credit;

   always_comb begin
      gnt_idx = '0;
      for (int k = 0; k < NUM_OF_PORTS; k++) begin
         if (arb_gnt[k]) gnt_idx = PORT_W'(k);
      end
   end

   // Ack comes only from registered state, so a request never reaches ack in the same cycle.
   always_comb begin
      ack = '0;
      for (int k = 0; k < NUM_OF_PORTS; k++) begin
         if (state == A_LOCKED && owner == PORT_W'(k) && has_credit) ack[k] = 1'b1;
      end
   end

   always_comb begin
      next_state  = state;
      next_owner  = owner;
      next_rr_ptr = rr_ptr;
      case (state)
         A_IDLE: begin
            if (arb_valid && has_credit) begin
               next_state = A_LOCKED;
               next_owner = gnt_idx;
            end
         end
         A_LOCKED: begin
            if (accept && bus.i_s2o.head.flit_type == TAIL_FLIT) begin
               next_state  = A_IDLE;
               next_rr_ptr = (owner == PORT_W'(NUM_OF_PORTS - 1)) ? '0 : owner + PORT_W'(1);
            end
         end
         default: next_state = A_IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state      <= A_IDLE;
         owner      <= '0;
         rr_ptr     <= '0;
         credits    <= FULL;
         link_flit  <= '0;
         link_valid <= 1'b0;
         credit_err <= 1'b0;
      end else begin
         state      <= next_state;
         owner      <= next_owner;
         rr_ptr     <= next_rr_ptr;
         link_valid <= accept;
         if (accept) link_flit <= bus.i_s2o;
         // A return and an accept in the same cycle cancel; a return into a full counter is an error.
         case ({accept, bus.i_credit_return})
            2'b10: credits <= credits - CREDIT_W'(1);
            2'b01: begin
               if (credits == FULL) credit_err <= 1'b1;
               else                 credits    <= credits + CREDIT_W'(1);
            end
            default: ;
         endcase
      end
   end

   assign bus.o_outport_ack = ack;
   assign bus.o_link_flit   = link_flit;
   assign bus.o_link_valid  = link_valid;
   assign bus.o_credits     = credits;
   assign bus.o_busy        = (state == A_LOCKED);
   assign bus.o_credit_err  = credit_err;

endmodule
